shift_serializer_tx: RTL and testbench

//   Parallel-to-serial transmitter that drives the serial input of the 8-bit

---
 rtl/shift_serializer_tx.sv | 111 +++++++++++
 tb/tb_shift_serializer_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_serializer_tx.sv
// Parallel-to-serial transmitter feeding a left/right shift-register receiver.
// Emits one bit per sl/sr strobe, ordered so the receiver ends up holding the word.
//
// state | meaning
// IDLE  | load_ready high, waiting for a word
// SHIFT | one strobe cycle, dout carries the current bit
// WAIT  | inter-strobe gap, strobes low, dout held
// DONE  | one-cycle done pulse, then back to IDLE
module shift_serializer_tx #(
   parameter int WIDTH = 8,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_dir,
   output logic             sl,
   output logic             sr,
   output logic             dout,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
   localparam logic [3:0]    GAP_LOAD = 4'(GAP - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] word;
   logic             dir;
   logic [CW-1:0]    cnt;
   logic [3:0]       gap_cnt;

   // Left mode sends MSB first, right mode LSB first.
   function automatic logic pick(input logic [WIDTH-1:0] w, input logic d,
                                 input logic [CW-1:0] idx);
      return d ? w[idx] : w[LAST - idx];
   endfunction

   assign load_ready = (state == IDLE);

   // Outputs are loaded alongside the state transition so they stay registered
   // yet line up with the state they belong to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         word    <= '0;
         dir     <= 1'b0;
         cnt     <= '0;
         gap_cnt <= '0;
         sl      <= 1'b0;
         sr      <= 1'b0;
         dout    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_valid) begin
                  word  <= load_data;
                  dir   <= load_dir;
                  cnt   <= '0;
                  state <= SHIFT;
                  sl    <= !load_dir;
                  sr    <= load_dir;
                  dout  <= pick(load_data, load_dir, '0);
                  busy  <= 1'b1;
               end
            end
            SHIFT: begin
               if (cnt == LAST) begin
                  state <= DONE;
                  sl    <= 1'b0;
                  sr    <= 1'b0;
                  done  <= 1'b1;
               end else if (GAP > 0) begin
                  state   <= WAIT;
                  sl      <= 1'b0;
                  sr      <= 1'b0;
                  gap_cnt <= GAP_LOAD;
                  cnt     <= cnt + CW'(1);
               end else begin
                  cnt  <= cnt + CW'(1);
                  dout <= pick(word, dir, cnt + CW'(1));
               end
            end
            WAIT: begin
               if (gap_cnt == 4'd0) begin
                  state <= SHIFT;
                  sl    <= !dir;
                  sr    <= dir;
                  dout  <= pick(word, dir, cnt);
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_serializer_tx.sv
// Directed bench for shift_serializer_tx: GAP=0 and GAP=2 instances, each with a
// behavioural shift-register receiver that reconstructs the transmitted word.
module tb_shift_serializer_tx;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic       load_valid = 1'b0, load_dir = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic       load_ready, sl, sr, dout, busy, done;

   logic       valid2 = 1'b0, dir2 = 1'b0;
   logic [7:0] data2 = 8'h00;
   logic       ready2, sl2, sr2, dout2, busy2, done2;

   shift_serializer_tx #(.WIDTH(8), .GAP(0)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_dir(load_dir), .sl(sl), .sr(sr), .dout(dout),
      .busy(busy), .done(done));

   shift_serializer_tx #(.WIDTH(8), .GAP(2)) dut2 (
      .clk(clk), .reset(reset), .load_valid(valid2), .load_ready(ready2),
      .load_data(data2), .load_dir(dir2), .sl(sl2), .sr(sr2), .dout(dout2),
      .busy(busy2), .done(done2));

   int checks = 0;
   int errors = 0;

   // receiver models and frame monitors
   int cyc = 0;
   bit clr = 1'b0;
   int nsl = 0, nsr = 0, first_s = -1, last_s = 0, done_c = 0, nacc = 0, ndone = 0;
   logic [7:0] rx = 8'h00, seq = 8'h00;
   logic [7:0] rx_log [2];
   int acc_log [2];
   int n2 = 0, first2 = -1, last2 = 0, done2_c = 0;
   logic [7:0] rx2 = 8'h00;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (clr) begin
         nsl <= 0; nsr <= 0; first_s <= -1; nacc <= 0; ndone <= 0;
         n2 <= 0; first2 <= -1;
      end else begin
         if (sl) nsl <= nsl + 1;
         if (sr) nsr <= nsr + 1;
         if (sl || sr) begin
            if (first_s < 0) first_s <= cyc;
            last_s <= cyc;
            seq <= {seq[6:0], dout};
         end
         if (sl) rx <= {rx[6:0], dout};
         if (sr) rx <= {dout, rx[7:1]};
         if (done) begin
            done_c <= cyc;
            if (ndone < 2) rx_log[ndone[0]] <= rx;
            ndone <= ndone + 1;
         end
         if (load_valid && load_ready) begin
            if (nacc < 2) acc_log[nacc[0]] <= cyc;
            nacc <= nacc + 1;
         end
         if (sl2 || sr2) begin
            n2 <= n2 + 1;
            if (first2 < 0) first2 <= cyc;
            last2 <= cyc;
         end
         if (sl2) rx2 <= {rx2[6:0], dout2};
         if (sr2) rx2 <= {dout2, rx2[7:1]};
         if (done2) done2_c <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic dr);
      int b = 0;
      load_valid = 1'b1; load_data = d; load_dir = dr;
      while (!load_ready && b < 50) begin @(negedge clk); b++; end
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic wait_done(input bit second);
      int b = 0;
      while (!(second ? done2 : done) && b < 100) begin @(negedge clk); b++; end
      chk("done_seen", {31'd0, second ? done2 : done}, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      int cnt, b, snap;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, load_ready}, 32'd1);
      chk("rst_sl", {31'd0, sl}, 32'd0);
      chk("rst_sr", {31'd0, sr}, 32'd0);
      chk("rst_dout", {31'd0, dout}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;

      // 8'h01 left mode, back-to-back strobes
      clear_mon();
      send(8'h01, 1'b0);
      chk("l_first_sl", {31'd0, sl}, 32'd1);
      chk("l_busy", {31'd0, busy}, 32'd1);
      chk("l_ready_low", {31'd0, load_ready}, 32'd0);
      wait_done(1'b0);
      chk("l_done_pulse", {31'd0, done}, 32'd0);
      chk("l_ready_back", {31'd0, load_ready}, 32'd1);
      chk("l_busy_end", {31'd0, busy}, 32'd0);
      chk("l_nsl", nsl, 32'd8);
      chk("l_nsr", nsr, 32'd0);
      chk("l_rx", {24'd0, rx}, 32'h01);
      chk("l_seq", {24'd0, seq}, 32'h01);
      chk("l_span", last_s - first_s, 32'd7);
      chk("l_done_lat", done_c - last_s, 32'd1);

      // 8'h01 right mode
      clear_mon();
      send(8'h01, 1'b1);
      chk("r_first_sr", {31'd0, sr}, 32'd1);
      wait_done(1'b0);
      chk("r_nsr", nsr, 32'd8);
      chk("r_nsl", nsl, 32'd0);
      chk("r_rx", {24'd0, rx}, 32'h01);
      chk("r_seq", {24'd0, seq}, 32'h80);

      // GAP=2 instance, 8'hC3 left mode
      clear_mon();
      valid2 = 1'b1; data2 = 8'hC3; dir2 = 1'b0;
      @(negedge clk);
      valid2 = 1'b0;
      wait_done(1'b1);
      chk("g_n", n2, 32'd8);
      chk("g_span", last2 - first2 + 1, 32'd22);
      chk("g_rx", {24'd0, rx2}, 32'hC3);
      chk("g_done_lat", done2_c - last2, 32'd1);

      // valid held high across two words
      clear_mon();
      load_valid = 1'b1; load_data = 8'hAA; load_dir = 1'b0;
      @(negedge clk);
      load_data = 8'h55;
      chk("bb_ready_low", {31'd0, load_ready}, 32'd0);
      b = 0;
      while (nacc < 2 && b < 100) begin @(negedge clk); b++; end
      load_valid = 1'b0;
      wait_done(1'b0);
      chk("bb_nacc", nacc, 32'd2);
      chk("bb_acc_gap", acc_log[1] - acc_log[0], 32'd10);
      chk("bb_ndone", ndone, 32'd2);
      chk("bb_rx0", {24'd0, rx_log[0]}, 32'hAA);
      chk("bb_rx1", {24'd0, rx_log[1]}, 32'h55);

      // inputs changed after acceptance
      clear_mon();
      send(8'h81, 1'b0);
      load_data = 8'h00; load_dir = 1'b1;
      wait_done(1'b0);
      chk("mf_rx", {24'd0, rx}, 32'h81);
      chk("mf_seq", {24'd0, seq}, 32'h81);
      chk("mf_nsl", nsl, 32'd8);
      chk("mf_nsr", nsr, 32'd0);

      // reset mid-frame after the 4th strobe of 8'hF0
      clear_mon();
      load_valid = 1'b1; load_data = 8'hF0; load_dir = 1'b0;
      @(negedge clk);
      load_valid = 1'b0;
      cnt = sl ? 1 : 0;
      b = 0;
      while (cnt < 4 && b < 50) begin
         @(negedge clk); b++;
         if (sl) cnt++;
      end
      chk("rm_strobes", cnt, 32'd4);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("rm_sl", {31'd0, sl}, 32'd0);
      chk("rm_sr", {31'd0, sr}, 32'd0);
      chk("rm_dout", {31'd0, dout}, 32'd0);
      chk("rm_busy", {31'd0, busy}, 32'd0);
      chk("rm_done", {31'd0, done}, 32'd0);
      chk("rm_ready", {31'd0, load_ready}, 32'd1);
      @(negedge clk) reset = 1'b0;
      snap = nsl;
      repeat (20) @(negedge clk);
      chk("rm_no_more", nsl, snap);
      chk("rm_idle_busy", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
